// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache with 16-byte lines.
// A miss writes back a dirty victim block, then refills the line from block
// memory. Loads that hit return data in the same cycle. Stores that hit
// merge the selected bytes into the line at the clock edge.
module data_cache #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int BLOCK_WIDTH   = 128,
  parameter int SETS          = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [1:0]               cpu_size,
  input  logic                     cpu_unsigned,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0]    cpu_wdata,
  output logic [DATA_WIDTH-1:0]    cpu_rdata,
  output logic                     cpu_stall,
  output logic                     mem_wr_en,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [BLOCK_WIDTH-1:0]   mem_wdata,
  output logic [ADDRESS_WIDTH-1:0] mem_read_addr,
  input  logic [BLOCK_WIDTH-1:0]   mem_rdata
);
  localparam int BYTES = BLOCK_WIDTH / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDRESS_WIDTH - IDX_W - OFF_W;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_ALLOCATE  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [TAG_W-1:0]       tag_mem  [SETS];
  logic [BLOCK_WIDTH-1:0] line_mem [SETS];
  logic [SETS-1:0]        valid_q;
  logic [SETS-1:0]        dirty_q;

  logic [OFF_W-1:0] offset;
  logic [IDX_W-1:0] index;
  logic [TAG_W-1:0] tag;
  logic             hit;
  logic             victim_dirty;
  logic             fill;
  logic             store_hit;

  // Extract the addressed byte/half/word from a line and extend it.
  // Half ignores the low address bit, word ignores the low two bits.
  function automatic logic [DATA_WIDTH-1:0] load_extend(
    input logic [BLOCK_WIDTH-1:0] line,
    input logic [OFF_W-1:0]       off,
    input logic [1:0]             size,
    input logic                   zext
  );
    logic [BLOCK_WIDTH-1:0] lane;
    logic signed [7:0]      b;
    logic signed [15:0]     h;
    logic [DATA_WIDTH-1:0]  r;
    case (size)
      2'b00: begin
        lane = line >> {off, 3'b000};
        b    = lane[7:0];
        r    = zext ? DATA_WIDTH'($unsigned(b)) : DATA_WIDTH'(b);
      end
      2'b01: begin
        lane = line >> {off[OFF_W-1:1], 4'b0000};
        h    = lane[15:0];
        r    = zext ? DATA_WIDTH'($unsigned(h)) : DATA_WIDTH'(h);
      end
      default: begin
        lane = line >> {off[OFF_W-1:2], 5'b00000};
        r    = lane[DATA_WIDTH-1:0];
      end
    endcase
    return r;
  endfunction

  // Merge right-aligned store data into the line; untouched lanes keep
  // their old bytes.
  function automatic logic [BLOCK_WIDTH-1:0] store_merge(
    input logic [BLOCK_WIDTH-1:0] line,
    input logic [OFF_W-1:0]       off,
    input logic [1:0]             size,
    input logic [DATA_WIDTH-1:0]  wdata
  );
    logic [BYTES-1:0]       be;
    logic [BLOCK_WIDTH-1:0] wide;
    logic [BLOCK_WIDTH-1:0] r;
    logic [OFF_W-1:0]       base;
    case (size)
      2'b00: begin
        base = off;
        be   = BYTES'(1) << base;
        wide = BLOCK_WIDTH'(wdata[7:0]) << {base, 3'b000};
      end
      2'b01: begin
        base = {off[OFF_W-1:1], 1'b0};
        be   = BYTES'(3) << base;
        wide = BLOCK_WIDTH'(wdata[15:0]) << {base, 3'b000};
      end
      default: begin
        base = {off[OFF_W-1:2], 2'b00};
        be   = BYTES'(15) << base;
        wide = BLOCK_WIDTH'(wdata) << {base, 3'b000};
      end
    endcase
    r = line;
    for (int i = 0; i < BYTES; i++) begin
      if (be[i]) r[i*8 +: 8] = wide[i*8 +: 8];
    end
    return r;
  endfunction

  assign offset        = cpu_addr[OFF_W-1:0];
  assign index         = cpu_addr[OFF_W +: IDX_W];
  assign tag           = cpu_addr[ADDRESS_WIDTH-1 -: TAG_W];
  assign hit           = cpu_req & valid_q[index] & (tag_mem[index] == tag);
  assign victim_dirty  = valid_q[index] & dirty_q[index];
  assign mem_addr      = {tag_mem[index], index, {OFF_W{1'b0}}};
  assign mem_wdata     = line_mem[index];
  assign mem_read_addr = {cpu_addr[ADDRESS_WIDTH-1:OFF_W], {OFF_W{1'b0}}};

  // Next-state and output decode; everything is forced quiet while reset is held.
  always_comb begin
    state_next = state;
    cpu_stall  = 1'b0;
    cpu_rdata  = '0;
    mem_wr_en  = 1'b0;
    fill       = 1'b0;
    store_hit  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (cpu_req) begin
          if (hit) begin
            if (cpu_we) store_hit = 1'b1;
            else cpu_rdata = load_extend(line_mem[index], offset, cpu_size, cpu_unsigned);
          end else begin
            cpu_stall  = 1'b1;
            state_next = victim_dirty ? S_WRITEBACK : S_ALLOCATE;
          end
        end
      end
      S_WRITEBACK: begin
        cpu_stall  = 1'b1;
        mem_wr_en  = 1'b1;
        state_next = S_ALLOCATE;
      end
      S_ALLOCATE: begin
        cpu_stall  = 1'b1;
        fill       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (!rst_n) begin
      cpu_stall = 1'b0;
      cpu_rdata = '0;
      mem_wr_en = 1'b0;
      fill      = 1'b0;
      store_hit = 1'b0;
    end
  end

  // Control state: FSM register plus per-line valid and dirty bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state <= state_next;
      if (fill) begin
        valid_q[index] <= 1'b1;
        dirty_q[index] <= 1'b0;
      end else if (store_hit) begin
        dirty_q[index] <= 1'b1;
      end
    end
  end

  // Tag and line storage: refill on allocate, byte merge on a store hit.
  always_ff @(posedge clk) begin
    if (fill) begin
      line_mem[index] <= mem_rdata;
      tag_mem[index]  <= tag;
    end else if (store_hit) begin
      line_mem[index] <= store_merge(line_mem[index], offset, cpu_size, cpu_wdata);
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Bench for data_cache: directed walkthrough, randomized accesses against a
// byte-level memory model, and reset during write-back.
module tb_data_cache;
  logic         clk;
  logic         rst_n;
  logic         cpu_req;
  logic         cpu_we;
  logic [1:0]   cpu_size;
  logic         cpu_unsigned;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic [31:0]  cpu_rdata;
  logic         cpu_stall;
  logic         mem_wr_en;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [31:0]  mem_read_addr;
  logic [127:0] mem_rdata;

  int tests = 0;
  int fails = 0;

  // Backing block memory (bench-owned) and architectural byte view.
  logic [127:0] bmem    [logic [31:0]];
  logic [7:0]   ref_mem [logic [31:0]];
  int           bmem_gen = 0;

  // Occupancy model: which block each set currently holds.
  bit           m_valid [256];
  bit           m_dirty [256];
  bit   [19:0]  m_tag   [256];

  int           wb_count = 0;
  logic [31:0]  last_wb_addr = '0;
  logic [127:0] last_wb_data = '0;

  data_cache dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_size     (cpu_size),
    .cpu_unsigned (cpu_unsigned),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .cpu_stall    (cpu_stall),
    .mem_wr_en    (mem_wr_en),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_read_addr(mem_read_addr),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] get_block(input logic [31:0] a);
    logic [127:0] blk;
    if (bmem.exists(a)) return bmem[a];
    for (int i = 0; i < 16; i++) blk[i*8 +: 8] = 8'(int'(a[19:4]) * 29 + i * 7 + 3);
    return blk;
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    logic [127:0] blk;
    if (ref_mem.exists(a)) return ref_mem[a];
    blk = get_block({a[31:4], 4'h0});
    return blk[int'(a[3:0]) * 8 +: 8];
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
    logic [31:0] v;
    logic [31:0] al;
    case (sz)
      2'd0: begin
        v = {24'h0, ref_byte(a)};
        if (!uns && v[7]) v = v | 32'hFFFF_FF00;
      end
      2'd1: begin
        al = {a[31:1], 1'b0};
        v  = {16'h0, ref_byte(al + 32'd1), ref_byte(al)};
        if (!uns && v[15]) v = v | 32'hFFFF_0000;
      end
      default: begin
        al = {a[31:2], 2'b00};
        v  = {ref_byte(al + 32'd3), ref_byte(al + 32'd2), ref_byte(al + 32'd1), ref_byte(al)};
      end
    endcase
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] al;
    int n;
    if (sz == 2'd0) begin al = a; n = 1; end
    else if (sz == 2'd1) begin al = {a[31:1], 1'b0}; n = 2; end
    else begin al = {a[31:2], 2'b00}; n = 4; end
    for (int i = 0; i < n; i++) ref_mem[al + 32'(i)] = wd[i*8 +: 8];
  endtask

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Combinational block read port.
  always @(mem_read_addr or bmem_gen) mem_rdata = get_block(mem_read_addr);

  // Single-cycle block write port.
  always @(posedge clk) begin
    if (mem_wr_en === 1'b1) begin
      bmem[mem_addr] = mem_wdata;
      bmem_gen++;
    end
  end

  // Every write-back must carry the current architectural contents of its block.
  always @(negedge clk) begin : wb_mon
    logic [127:0] eb;
    if (rst_n === 1'b1 && mem_wr_en === 1'b1) begin
      for (int i = 0; i < 16; i++) eb[i*8 +: 8] = ref_byte(mem_addr + 32'(i));
      check("wb_data", mem_wdata, eb);
      wb_count++;
      last_wb_addr = mem_addr;
      last_wb_data = mem_wdata;
    end
  end

  // One CPU access, entered and left at 1 time unit after a rising edge.
  task automatic access(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output int stalls);
    int          idx;
    bit          hit;
    int          exp_wb;
    int          exp_st;
    int          wb0;
    logic [31:0] exp_rd;
    logic [31:0] vic;
    idx    = int'(a[11:4]);
    hit    = m_valid[idx] && (m_tag[idx] == a[31:12]);
    exp_wb = (!hit && m_valid[idx] && m_dirty[idx]) ? 1 : 0;
    exp_st = hit ? 0 : ((exp_wb == 1) ? 3 : 2);
    vic    = {m_tag[idx], a[11:4], 4'h0};
    exp_rd = ref_load(a, sz, uns);
    wb0    = wb_count;
    cpu_req      = 1'b1;
    cpu_we       = we;
    cpu_size     = sz;
    cpu_unsigned = uns;
    cpu_addr     = a;
    cpu_wdata    = wd;
    stalls = 0;
    @(negedge clk);
    while (cpu_stall === 1'b1 && stalls < 8) begin
      stalls++;
      @(negedge clk);
    end
    check("stall_cycles", 128'(stalls), 128'(exp_st));
    rd = cpu_rdata;
    if (!we) check("load_data", cpu_rdata, exp_rd);
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    check("wb_count", 128'(wb_count - wb0), 128'(exp_wb));
    if (exp_wb == 1) check("wb_addr", last_wb_addr, vic);
    if (!hit) begin
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = a[31:12];
    end
    if (we) begin
      m_dirty[idx] = 1'b1;
      ref_store(a, sz, wd);
    end
  endtask

  initial begin : stim
    logic [31:0] rd;
    int          st;
    int          g;
    logic [31:0] a;
    rst_n        = 1'b0;
    cpu_req      = 1'b1;
    cpu_we       = 1'b0;
    cpu_size     = 2'd2;
    cpu_unsigned = 1'b0;
    cpu_addr     = 32'h0001_0000;
    cpu_wdata    = '0;
    bmem[32'h0001_0000] = {96'hCAFE_0000_1111_2222_3333_4444, 32'h1234_5678};
    bmem_gen++;

    // Reset holds outputs quiet even with a missing request pending.
    #2;
    check("rst_stall", cpu_stall, 1'b0);
    check("rst_rdata", cpu_rdata, 32'h0);
    check("rst_wr_en", mem_wr_en, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    cpu_req = 1'b0;
    @(negedge clk);
    check("idle_stall", cpu_stall, 1'b0);
    check("idle_rdata", cpu_rdata, 32'h0);
    @(posedge clk);
    #1;

    // Directed walkthrough.
    access(1'b0, 2'd2, 1'b0, 32'h0001_0000, 32'h0, rd, st);
    check("lw_first", rd, 32'h1234_5678);
    check("lw_first_stall", 128'(st), 128'd2);
    check("lw_first_nowb", 128'(wb_count), 128'd0);
    access(1'b1, 2'd0, 1'b0, 32'h0001_0001, 32'h0000_00AB, rd, st);
    check("sb_stall", 128'(st), 128'd0);
    access(1'b0, 2'd2, 1'b0, 32'h0001_0000, 32'h0, rd, st);
    check("lw_after_sb", rd, 32'h1234_AB78);
    access(1'b0, 2'd0, 1'b1, 32'h0001_0001, 32'h0, rd, st);
    check("lbu", rd, 32'h0000_00AB);
    access(1'b0, 2'd0, 1'b0, 32'h0001_0001, 32'h0, rd, st);
    check("lb", rd, 32'hFFFF_FFAB);
    access(1'b1, 2'd1, 1'b0, 32'h0001_0006, 32'h0000_FFFE, rd, st);
    access(1'b0, 2'd1, 1'b0, 32'h0001_0006, 32'h0, rd, st);
    check("lh", rd, 32'hFFFF_FFFE);
    access(1'b0, 2'd1, 1'b1, 32'h0001_0006, 32'h0, rd, st);
    check("lhu", rd, 32'h0000_FFFE);
    access(1'b0, 2'd1, 1'b0, 32'h0001_0007, 32'h0, rd, st);
    check("lh_odd", rd, 32'hFFFF_FFFE);
    check("no_wb_yet", 128'(wb_count), 128'd0);
    access(1'b0, 2'd2, 1'b0, 32'h0001_1000, 32'h0, rd, st);
    check("dirty_miss_stall", 128'(st), 128'd3);
    check("dirty_wb_count", 128'(wb_count), 128'd1);
    check("dirty_wb_addr", last_wb_addr, 32'h0001_0000);
    check("dirty_wb_word0", last_wb_data[31:0], 32'h1234_AB78);
    access(1'b0, 2'd2, 1'b0, 32'h0001_0000, 32'h0, rd, st);
    check("clean_miss_stall", 128'(st), 128'd2);
    check("clean_miss_nowb", 128'(wb_count), 128'd1);
    check("persisted", rd, 32'h1234_AB78);

    // Randomized conflicting traffic over a few sets and tags.
    for (int n = 0; n < 250; n++) begin
      a = {12'h000, 8'(8'h10 + 8'($urandom_range(0, 3))), 8'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
      access(($urandom_range(0, 9) < 4) ? 1'b1 : 1'b0, 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), a, $urandom, rd, st);
    end

    // Reset in the middle of a write-back drops it and invalidates the cache.
    access(1'b1, 2'd2, 1'b0, 32'h0001_0000, 32'hDEAD_BEEF, rd, st);
    cpu_req      = 1'b1;
    cpu_we       = 1'b0;
    cpu_size     = 2'd2;
    cpu_unsigned = 1'b0;
    cpu_addr     = 32'h0001_1000;
    @(negedge clk);
    check("abort_miss_stall", cpu_stall, 1'b1);
    @(posedge clk);
    #1;
    check("abort_in_wb", mem_wr_en, 1'b1);
    check("abort_wb_addr", mem_addr, 32'h0001_0000);
    g = bmem_gen;
    rst_n = 1'b0;
    #1;
    check("abort_wr_en_low", mem_wr_en, 1'b0);
    check("abort_stall_low", cpu_stall, 1'b0);
    check("abort_rdata_zero", cpu_rdata, 32'h0);
    cpu_req = 1'b0;
    @(posedge clk);
    #1;
    check("abort_no_mem_write", 128'(bmem_gen), 128'(g));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ref_mem.delete();
    for (int i = 0; i < 256; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    access(1'b0, 2'd2, 1'b0, 32'h0001_0000, 32'h0, rd, st);
    check("post_reset_miss", 128'(st), 128'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
